// File: rtl/gb_pkg.sv
// Shared Game Boy constants and types for the OAM DMA engine.
package gb_pkg;

    localparam logic [15:0] OAM_BASE    = 16'hfe00;
    localparam int          OAM_LENGTH  = 160;
    localparam logic [15:0] DMA_REG     = 16'hff46;
    localparam logic [7:0]  ECHO_LO     = 8'he0;
    localparam logic [7:0]  ECHO_OFFSET = 8'h20;

    typedef enum logic [1:0] {IDLE, START, READ, WRITE} dma_state_t;

    // Pages E0-FF mirror work RAM at C0-DF.
    function automatic logic [7:0] dma_src_hi(input logic [7:0] page);
        return (page >= ECHO_LO) ? page - ECHO_OFFSET : page;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a store to the trigger register copies LENGTH bytes from
// page P into sprite attribute memory using a READ/WRITE bus sequencer.
module oam_dma
    import gb_pkg::*;
#(
    parameter logic [15:0] REG_ADDR    = DMA_REG,
    parameter logic [15:0] DST_BASE    = OAM_BASE,
    parameter int          LENGTH      = OAM_LENGTH,
    parameter int          START_DELAY = 1
) (
    input  logic        clockgb,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    output logic        dma_active,
    output logic [15:0] dma_address,
    output logic [7:0]  dma_outdata,
    input  logic [7:0]  dma_indata,
    output logic        dma_load,
    output logic        dma_store
);

    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    dma_state_t  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  outdata_q, outdata_d;
    logic        dma_active_q, dma_active_d;
    logic [15:0] dma_address_q, dma_address_d;
    logic        dma_load_q, dma_load_d;
    logic        dma_store_q, dma_store_d;

    logic reg_store;
    logic reg_load;

    assign reg_store = store && (address == REG_ADDR);
    assign reg_load  = load && (address == REG_ADDR);

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        count_d = count_q;

        unique case (state_q)
            START: begin
                if (int'(count_q) + 1 >= START_DELAY) begin
                    state_d = READ;
                    index_d = 8'h00;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            READ:  state_d = WRITE;
            WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = READ;
                end
            end
            default: ;
        endcase

        // A trigger wins over everything; the bus cycle already on the outputs still completes.
        if (reg_store) begin
            page_d  = indata;
            index_d = 8'h00;
            count_d = 8'h00;
            state_d = (START_DELAY == 0) ? READ : START;
        end
    end

    always_comb begin
        dma_active_d  = (state_d != IDLE);
        dma_load_d    = (state_d == READ);
        dma_store_d   = (state_d == WRITE);
        dma_address_d = 16'h0000;
        if (state_d == READ)
            dma_address_d = {dma_src_hi(page_d), index_d};
        else if (state_d == WRITE)
            dma_address_d = DST_BASE + {8'h00, index_d};
        outdata_d = reg_load ? page_q : 8'h00;
    end

    always_ff @(posedge clockgb or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            page_q        <= 8'h00;
            index_q       <= 8'h00;
            count_q       <= 8'h00;
            outdata_q     <= 8'h00;
            dma_active_q  <= 1'b0;
            dma_address_q <= 16'h0000;
            dma_load_q    <= 1'b0;
            dma_store_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            index_q       <= index_d;
            count_q       <= count_d;
            outdata_q     <= outdata_d;
            dma_active_q  <= dma_active_d;
            dma_address_q <= dma_address_d;
            dma_load_q    <= dma_load_d;
            dma_store_q   <= dma_store_d;
        end
    end

    assign outdata     = outdata_q;
    assign dma_active  = dma_active_q;
    assign dma_address = dma_address_q;
    assign dma_load    = dma_load_q;
    assign dma_store   = dma_store_q;

    // Read data only arrives in the WRITE cycle itself, so it is forwarded rather than registered.
    assign dma_outdata = dma_store_q ? dma_indata : 8'h00;

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Bus-initiator OAM DMA engine at register FF46.
- A CPU store of page value P copies 160 bytes from P00..P9F into sprite attribute memory FE00..FE9F.
- Masters the system bus through a dedicated port; the top level muxes that port over the CPU bus while dma_active is high.
- It is the writing end of the sprite-table interface the PPU exposes at FE00.

Parameters:
- REG_ADDR, 16'hff46, CPU-visible trigger/readback register address.
- DST_BASE, 16'hfe00, destination (OAM) base address.
- LENGTH, 160, bytes per transfer; must be less than or equal to 256.
- START_DELAY, 1, idle cycles between trigger store and first bus read.

Ports:
- clockgb  in  1  system (GB) clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- address  in  16  CPU bus address
- indata  in  8  CPU store data
- outdata  out  8  CPU read data; zero unless a register read is pending (OR-bus convention)
- load  in  1  CPU load strobe
- store  in  1  CPU store strobe
- dma_active  out  1  high while a transfer owns the bus (START, READ, WRITE)
- dma_address  out  16  initiator bus address
- dma_outdata  out  8  initiator write data
- dma_indata  in  8  initiator read data, valid exactly one cycle after dma_load
- dma_load  out  1  initiator read strobe
- dma_store  out  1  initiator write strobe

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, page=8'h00, index=0, outdata=0, dma_active=0, dma_address=0, dma_outdata=0, dma_load=0, dma_store=0.
  - Asserting reset mid-transfer aborts it; the transfer does not resume after reset releases.
- Register access:
  - store with address==REG_ADDR latches page<=indata and puts the engine in START with count=0.
  - load with address==REG_ADDR makes outdata=page on the next cycle; outdata is 0 in every other cycle.
  - Both accesses are accepted in any state.
- Source mapping:
  - src_hi = page for pages 00-DF.
  - src_hi = page-8'h20 for pages E0-FF (echo RAM folded onto C0-DF).
  - Source address = {src_hi, index}; destination address = DST_BASE + index.
  - index is 8 bits and never wraps within a transfer.
- State machine (registered outputs):
  - IDLE: all strobes 0, dma_active=0.
  - START: count down START_DELAY cycles with dma_active=1 and no strobes, then go to READ with index=0.
  - READ: dma_load=1, dma_address=source address, then go to WRITE.
  - WRITE:
    - dma_store=1, dma_address=destination address, dma_outdata=dma_indata captured from the READ cycle.
    - If index==LENGTH-1, go to IDLE; otherwise index+1 and go to READ.
  - dma_load and dma_store are never high in the same cycle.
- Latency:
  - Trigger store in cycle T gives the first dma_load in cycle T+1+START_DELAY.
  - The last dma_store is in cycle T+START_DELAY+2*LENGTH.
  - dma_active drops in the following cycle; 321 cycles at defaults.
- Retrigger: a store to REG_ADDR during START/READ/WRITE abandons the current transfer. On the next cycle the engine is in START with the new page and index=0. Bytes already written stay in OAM.
- Simultaneous events: a store to REG_ADDR in the same cycle as the final WRITE lets the final write complete and the next state is START, not IDLE.
- Bus ownership:
  - The block does not stall the CPU.
  - While dma_active is high the top level gives the system bus to the dma_* port.
  - CPU accesses other than REG_ADDR are the top level's responsibility.

Decomposition:
- Shared package gb_pkg holds:
  - constants OAM_BASE=16'hfe00, OAM_LENGTH=160, DMA_REG=16'hff46, ECHO_LO=8'he0, ECHO_OFFSET=8'h20;
  - an enum dma_state_t {IDLE, START, READ, WRITE}.
- No sub-module: the register decode and the 2-cycle read/write sequencer are small enough to stay inline.

Test Plan:
- Trigger: store 8'hc1 to FF46 -> first dma_load at T+2 with dma_address=C100; dma_store at T+3 with dma_address=FE00 and dma_outdata equal to the model value at C100; last store FE9F/C19F at T+321; dma_active low at T+322.
- Echo page: store 8'he3 -> reads come from C300..C39F; OAM contents match a C3xx pattern.
- Readback: store 8'h80, then load FF46 -> outdata=8'h80 for exactly one cycle; outdata=0 on a load from FF45.
- Retrigger: store 8'hc0, then store 8'hd0 at byte 50 -> OAM 00-49 hold C0xx data; the final image holds D000..D09F; total active cycles = 51*2+... per the latency rule from the second store.
- Reset: assert reset at byte 80 -> all outputs 0 asynchronously, no strobe after release, outdata=0 and page=0 on readback.
- Final-byte collision: store 8'hc2 in the WRITE cycle for index 159 -> the FE9F write completes, then a new transfer starts from C200 with no IDLE cycle.
